// File: rtl/caliptra_axi2vh_pkg.sv
// Shared types and constants for the AXI4-Lite to Valid-Hold bridge.
package caliptra_axi2vh_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_REQ = 3'd1,
        ST_WR_RSP = 3'd2,
        ST_RD_REQ = 3'd3,
        ST_RD_RSP = 3'd4
    } axi2vh_state_e;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [2:0] VH_SIZE_WORD = 3'd2;

    function automatic logic [1:0] vh_resp(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/caliptra_axi2vh_arb.sv
// Two-requester round-robin arbiter; the priority bit flips after every grant.
module caliptra_axi2vh_arb (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_en,
    input  logic i_req_wr,
    input  logic i_req_rd,
    output logic o_gnt_wr,
    output logic o_gnt_rd
);

    logic r_rd_first;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        o_gnt_wr = 1'b0;
        o_gnt_rd = 1'b0;
        if (i_en) begin
            if (i_req_wr && (!i_req_rd || !r_rd_first)) begin
                o_gnt_wr = 1'b1;
            end else if (i_req_rd) begin
                o_gnt_rd = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_first <= 1'b0;
        end else if (o_gnt_wr || o_gnt_rd) begin
            r_rd_first <= ~r_rd_first;
        end
    end

endmodule

// File: rtl/caliptra_axi_lite_to_vh.sv
// AXI4-Lite subordinate issuing one Valid-Hold request at a time.
// Optional alignment/strobe checking is enabled with CALIPTRA_AXI2VH_ADDR_CHECK_EN.
module caliptra_axi_lite_to_vh
    import caliptra_axi2vh_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [USER_WIDTH-1:0]   awuser_i,

    input  logic                    wvalid_i,
    output logic                    wready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,

    output logic                    bvalid_o,
    input  logic                    bready_i,
    output logic [1:0]              bresp_o,
    output logic [ID_WIDTH-1:0]     bid_o,

    input  logic                    arvalid_i,
    output logic                    arready_o,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [USER_WIDTH-1:0]   aruser_i,

    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic                    rlast_o,

    output logic                    dv_o,
    input  logic                    hld_i,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    write_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic [2:0]              size_o,
    output logic                    last_o,
    output logic [USER_WIDTH-1:0]   user_o,
    output logic [ID_WIDTH-1:0]     id_o,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic                    error_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    axi2vh_state_e r_state, w_state_nxt;

    logic                  w_gnt_wr, w_gnt_rd, w_accept, w_vh_done, w_acc_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [USER_WIDTH-1:0] r_user;
    logic [ID_WIDTH-1:0]   r_id;
    logic [1:0]            r_resp;

    caliptra_axi2vh_arb u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_en     (r_state == ST_IDLE),
        .i_req_wr (awvalid_i && wvalid_i),
        .i_req_rd (arvalid_i),
        .o_gnt_wr (w_gnt_wr),
        .o_gnt_rd (w_gnt_rd)
    );

    assign w_accept  = w_gnt_wr || w_gnt_rd;
    assign w_vh_done = dv_o && !hld_i;

`ifdef CALIPTRA_AXI2VH_ADDR_CHECK_EN
    // Misaligned or strobe-less requests are answered locally, never reaching VH.
    assign w_acc_err = w_gnt_wr ? ((awaddr_i[1:0] != 2'b00) || (wstrb_i == '0))
                                : (araddr_i[1:0] != 2'b00);
`else
    assign w_acc_err = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_gnt_wr) begin
                    w_state_nxt = w_acc_err ? ST_WR_RSP : ST_WR_REQ;
                end else if (w_gnt_rd) begin
                    w_state_nxt = w_acc_err ? ST_RD_RSP : ST_RD_REQ;
                end
            end
            ST_WR_REQ: if (!hld_i)    w_state_nxt = ST_WR_RSP;
            ST_RD_REQ: if (!hld_i)    w_state_nxt = ST_RD_RSP;
            ST_WR_RSP: if (bready_i)  w_state_nxt = ST_IDLE;
            ST_RD_RSP: if (rready_i)  w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the request/response holding registers are few and feed outputs, so they are reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_user  <= '0;
            r_id    <= '0;
            r_rdata <= '0;
            r_resp  <= RESP_OKAY;
        end else if (w_accept) begin
            r_addr  <= w_gnt_wr ? awaddr_i : araddr_i;
            r_user  <= w_gnt_wr ? awuser_i : aruser_i;
            r_id    <= w_gnt_wr ? awid_i   : arid_i;
            r_wdata <= w_gnt_wr ? wdata_i  : '0;
            r_wstrb <= w_gnt_wr ? wstrb_i  : '1;
            r_rdata <= '0;
            r_resp  <= vh_resp(w_acc_err);
        end else if (w_vh_done) begin
            r_rdata <= rdata_i;
            r_resp  <= vh_resp(error_i);
        end
    end

    assign awready_o = w_gnt_wr;
    assign wready_o  = w_gnt_wr;
    assign arready_o = w_gnt_rd;

    assign dv_o    = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ);
    assign write_o = (r_state == ST_WR_REQ);
    assign addr_o  = r_addr;
    assign wdata_o = r_wdata;
    assign wstrb_o = r_wstrb;
    assign user_o  = r_user;
    assign id_o    = r_id;
    assign size_o  = VH_SIZE_WORD;
    assign last_o  = 1'b1;

    assign bvalid_o = (r_state == ST_WR_RSP);
    assign bresp_o  = r_resp;
    assign bid_o    = r_id;

    assign rvalid_o = (r_state == ST_RD_RSP);
    assign rdata_o  = r_rdata;
    assign rresp_o  = r_resp;
    assign rid_o    = r_id;
    assign rlast_o  = 1'b1;

endmodule

// File: tb/tb_caliptra_axi_lite_to_vh.sv
// Randomized self-checking bench: AXI master + VH responder against a transaction-level model.
module tb_caliptra_axi_lite_to_vh;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        awvalid_i, awready_o, wvalid_i, wready_o;
    logic [31:0] awaddr_i, awuser_i, wdata_i;
    logic [7:0]  awid_i;
    logic [3:0]  wstrb_i;
    logic        bvalid_o, bready_i;
    logic [1:0]  bresp_o;
    logic [7:0]  bid_o;
    logic        arvalid_i, arready_o;
    logic [31:0] araddr_i, aruser_i;
    logic [7:0]  arid_i;
    logic        rvalid_o, rready_i, rlast_o;
    logic [31:0] rdata_o;
    logic [1:0]  rresp_o;
    logic [7:0]  rid_o;
    logic        dv_o, hld_i, write_o, last_o, error_i;
    logic [31:0] addr_o, wdata_o, user_o, rdata_i;
    logic [3:0]  wstrb_o;
    logic [2:0]  size_o;
    logic [7:0]  id_o;

    always #5 clk_i = ~clk_i;

    caliptra_axi_lite_to_vh dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .awvalid_i(awvalid_i), .awready_o(awready_o), .awaddr_i(awaddr_i),
        .awid_i(awid_i), .awuser_i(awuser_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .bvalid_o(bvalid_o), .bready_i(bready_i), .bresp_o(bresp_o), .bid_o(bid_o),
        .arvalid_i(arvalid_i), .arready_o(arready_o), .araddr_i(araddr_i),
        .arid_i(arid_i), .aruser_i(aruser_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .rresp_o(rresp_o),
        .rid_o(rid_o), .rlast_o(rlast_o),
        .dv_o(dv_o), .hld_i(hld_i), .addr_o(addr_o), .write_o(write_o),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .size_o(size_o), .last_o(last_o),
        .user_o(user_o), .id_o(id_o), .rdata_i(rdata_i), .error_i(error_i)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_grants = 0;   // model: contested winner is write when even, read when odd
    bit addr_chk_en;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(5, 0) == 0) a[1:0] = 2'($urandom);
        return a;
    endfunction

    task automatic new_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [7:0] id, input logic [31:0] u);
        awaddr_i = a; wdata_i = d; wstrb_i = s; awid_i = id; awuser_i = u;
        awvalid_i = 1'b1; wvalid_i = 1'b1;
    endtask

    task automatic new_read(input logic [31:0] a, input logic [7:0] id, input logic [31:0] u);
        araddr_i = a; arid_i = id; aruser_i = u;
        arvalid_i = 1'b1;
    endtask

    // One granted transaction from whatever requests are currently presented.
    task automatic do_txn(input int hold, input bit err, input int rdy_dly, input logic [31:0] vh_rdata);
        bit          req_wr, req_rd, exp_wr, bad;
        logic [31:0] e_addr, e_user, e_wdata, e_rdata;
        logic [7:0]  e_id;
        logic [3:0]  e_strb;
        logic [1:0]  e_resp;
        req_wr = awvalid_i && wvalid_i;
        req_rd = arvalid_i;
        #1;
        exp_wr = req_wr && (!req_rd || (n_grants % 2 == 0));
        check("awready", 64'(awready_o), 64'(exp_wr));
        check("wready",  64'(wready_o),  64'(exp_wr));
        check("arready", 64'(arready_o), 64'(!exp_wr && req_rd));
        e_addr  = exp_wr ? awaddr_i : araddr_i;
        e_user  = exp_wr ? awuser_i : aruser_i;
        e_id    = exp_wr ? awid_i   : arid_i;
        e_wdata = exp_wr ? wdata_i  : 32'h0;
        e_strb  = exp_wr ? wstrb_i  : 4'hF;
        bad     = addr_chk_en && ((e_addr[1:0] != 2'b00) || (exp_wr && e_strb == 4'h0));
        e_resp  = (bad || err) ? 2'b10 : 2'b00;
        e_rdata = bad ? 32'h0 : vh_rdata;
        tick();
        n_grants++;
        if (exp_wr) begin awvalid_i = 1'b0; wvalid_i = 1'b0; end
        else arvalid_i = 1'b0;

        if (!bad) begin
            for (int i = 0; i <= hold; i++) begin
                hld_i   = (i < hold);
                error_i = (i == hold) ? err : 1'($urandom);
                rdata_i = (i == hold) ? vh_rdata : $urandom;
                check("dv_o",   64'(dv_o),   64'(1));
                check("addr_o", 64'(addr_o), 64'(e_addr));
                if (i == 0) begin
                    check("write_o", 64'(write_o), 64'(exp_wr));
                    check("wdata_o", 64'(wdata_o), 64'(e_wdata));
                    check("wstrb_o", 64'(wstrb_o), 64'(e_strb));
                    check("id_o",    64'(id_o),    64'(e_id));
                    check("user_o",  64'(user_o),  64'(e_user));
                    check("size_o",  64'(size_o),  64'(2));
                    check("last_o",  64'(last_o),  64'(1));
                end
                check("req_no_accept", 64'(awready_o | wready_o | arready_o), 64'(0));
                tick();
            end
            hld_i = 1'b0; error_i = 1'b0; rdata_i = $urandom;
        end
        check("dv_drop", 64'(dv_o), 64'(0));

        for (int i = 0; i <= rdy_dly; i++) begin
            if (exp_wr) bready_i = (i == rdy_dly);
            else        rready_i = (i == rdy_dly);
            if (exp_wr) begin
                check("bvalid", 64'(bvalid_o), 64'(1));
                check("rvalid_idle", 64'(rvalid_o), 64'(0));
                check("bresp",  64'(bresp_o),  64'(e_resp));
                check("bid",    64'(bid_o),    64'(e_id));
            end else begin
                check("rvalid", 64'(rvalid_o), 64'(1));
                check("bvalid_idle", 64'(bvalid_o), 64'(0));
                check("rresp",  64'(rresp_o),  64'(e_resp));
                check("rid",    64'(rid_o),    64'(e_id));
                check("rdata",  64'(rdata_o),  64'(e_rdata));
                check("rlast",  64'(rlast_o),  64'(1));
            end
            check("rsp_no_accept", 64'(awready_o | wready_o | arready_o), 64'(0));
            tick();
        end
        bready_i = 1'b0; rready_i = 1'b0;
        check("rsp_done", 64'(bvalid_o | rvalid_o), 64'(0));
    endtask

    initial begin
`ifdef CALIPTRA_AXI2VH_ADDR_CHECK_EN
        addr_chk_en = 1'b1;
`else
        addr_chk_en = 1'b0;
`endif
        rst_ni = 1'b0;
        awvalid_i = 0; wvalid_i = 0; arvalid_i = 0; bready_i = 0; rready_i = 0;
        awaddr_i = 0; awid_i = 0; awuser_i = 0; wdata_i = 0; wstrb_i = 0;
        araddr_i = 0; arid_i = 0; aruser_i = 0;
        hld_i = 0; error_i = 0; rdata_i = 0;
        repeat (3) tick();
        check("rst_dv",     64'(dv_o),     64'(0));
        check("rst_bvalid", 64'(bvalid_o), 64'(0));
        check("rst_rvalid", 64'(rvalid_o), 64'(0));
        check("rst_ready",  64'(awready_o | wready_o | arready_o), 64'(0));
        check("rst_resp",   64'({bresp_o, rresp_o}), 64'(0));
        check("rst_addr",   64'(addr_o),   64'(0));
        check("rst_rdata",  64'(rdata_o),  64'(0));
        rst_ni = 1'b1;
        tick();

        // Basic write, then stalled read with slow R ready.
        new_write(32'h40, 32'hDEAD_BEEF, 4'hF, 8'h5A, 32'h1111_0000);
        do_txn(0, 1'b0, 0, 32'h0);
        new_read(32'h44, 8'hA7, 32'h2222_0000);
        do_txn(5, 1'b0, 4, 32'h1234_5678);

        // VH error on write, next transaction clean.
        new_write(32'h80, 32'hCAFE_F00D, 4'h3, 8'h11, 32'h0);
        do_txn(1, 1'b1, 1, 32'h0);
        new_read(32'h84, 8'h12, 32'h0);
        do_txn(0, 1'b0, 0, 32'h0BAD_CAFE);

        // Contention twice in a row; losing read waits through a slow response.
        for (int r = 0; r < 2; r++) begin
            new_write(32'h100 + 32'(r * 8), $urandom, 4'hF, 8'(8'h20 + r), $urandom);
            new_read(32'h200 + 32'(r * 8), 8'(8'h30 + r), $urandom);
            do_txn(0, 1'b0, 4, 32'h0);
            do_txn(2, 1'b0, 1, $urandom);
        end
        new_write(32'h300, $urandom, 4'hF, 8'h40, $urandom);
        new_read(32'h304, 8'h41, $urandom);
        do_txn(0, 1'b0, 0, 32'h0);
        do_txn(0, 1'b0, 0, 32'h5555_AAAA);

        // Misaligned read.
        new_read(32'h42, 8'h77, 32'h0);
        do_txn(0, 1'b0, 0, 32'hFEED_FACE);

        // Randomized traffic.
        for (int k = 0; k < 60; k++) begin
            if (!awvalid_i && ($urandom_range(1, 0) == 1))
                new_write(rand_addr(), $urandom,
                          ($urandom_range(7, 0) == 0) ? 4'h0 : 4'($urandom), 8'($urandom), $urandom);
            if (!arvalid_i && ($urandom_range(1, 0) == 1))
                new_read(rand_addr(), 8'($urandom), $urandom);
            if (!awvalid_i && !arvalid_i)
                new_read(rand_addr(), 8'($urandom), $urandom);
            do_txn($urandom_range(3, 0), ($urandom_range(3, 0) == 0), $urandom_range(2, 0), $urandom);
        end
        for (int k = 0; k < 2; k++) begin
            if (awvalid_i || arvalid_i) do_txn(0, 1'b0, 0, $urandom);
        end

        // Asynchronous reset during a stalled write request.
        new_write(32'h500, 32'h1, 4'hF, 8'h9, 32'h0);
        tick();
        awvalid_i = 0; wvalid_i = 0; hld_i = 1'b1;
        check("mid_dv_before", 64'(dv_o), 64'(1));
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_dv",     64'(dv_o),     64'(0));
        check("mid_rst_bvalid", 64'(bvalid_o), 64'(0));
        tick();
        hld_i = 1'b0;
        rst_ni = 1'b1;
        n_grants = 0;
        tick();
        check("post_rst_bvalid", 64'(bvalid_o), 64'(0));
        new_write(32'h600, 32'h600D_600D, 4'hF, 8'h61, 32'h0);
        new_read(32'h604, 8'h62, 32'h0);
        do_txn(0, 1'b0, 0, 32'h0);
        do_txn(0, 1'b0, 0, 32'h7777_8888);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
